// File: rtl/fp_pkg.sv
// Shared definitions for the sequential floating-point add/sub unit:
// FSM state encoding, flag bit positions and special-value patterns.
package fp_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ALIGN = 3'd1,
      S_ADD   = 3'd2,
      S_NORM  = 3'd3,
      S_ROUND = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   localparam int FLG_NV = 3;
   localparam int FLG_OF = 2;
   localparam int FLG_UF = 1;
   localparam int FLG_NX = 0;

   // Canonical quiet NaN: sign 0, exponent all ones, fraction MSB set.
   // Returned in a wide container; callers truncate to their operand width.
   function automatic logic [63:0] fp_qnan(input int exp_w, input int man_w);
      logic [63:0] v;
      v = ((64'd1 << exp_w) - 64'd1) << man_w;
      v = v | (64'd1 << (man_w - 1));
      return v;
   endfunction

   // Infinity magnitude (sign bit clear): exponent all ones, fraction zero.
   function automatic logic [63:0] fp_inf(input int exp_w, input int man_w);
      logic [63:0] v;
      v = ((64'd1 << exp_w) - 64'd1) << man_w;
      return v;
   endfunction

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter; an all-zero input reports WIDTH.
module fp_lzc #(
   parameter int  WIDTH = 27,
   localparam int CW    = $clog2(WIDTH + 1)
) (
   input  logic [WIDTH-1:0] din,
   output logic [CW-1:0]    count
);

   // Scan upward so the highest set bit determines the final count
   always_comb begin
      count = CW'(WIDTH);
      for (int i = 0; i < WIDTH; i++) begin
         count = din[i] ? CW'(WIDTH - 1 - i) : count;
      end
   end

endmodule

// File: rtl/fp_addsub_seq.sv
// Multi-cycle floating-point adder/subtractor with fixed five-cycle latency.
// Stages: ALIGN -> ADD -> NORM -> ROUND -> DONE, each stage registered.
// Subnormal inputs and tiny results are flushed to signed zero.
module fp_addsub_seq
   import fp_pkg::*;
#(
   parameter int  EXP_W = 8,
   parameter int  MAN_W = 23,
   localparam int W     = 1 + EXP_W + MAN_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic         op_sub,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] result,
   output logic [3:0]   flags,
   output logic         busy,
   output logic         done
);

   localparam int MW  = MAN_W + 4;          // {hidden, frac, G, R, S}
   localparam int SW  = MAN_W + 5;          // adder width with carry
   localparam int EW  = EXP_W + 2;          // signed working exponent
   localparam int LZW = $clog2(MW + 1);
   localparam logic [W-1:0]          QNAN     = W'(fp_qnan(EXP_W, MAN_W));
   localparam logic [W-2:0]          INF_MAG  = (W-1)'(fp_inf(EXP_W, MAN_W));
   localparam logic [EXP_W-1:0]      EXP_ONES = {EXP_W{1'b1}};
   localparam logic [EXP_W-1:0]      EXP_ZERO = {EXP_W{1'b0}};
   localparam logic [EXP_W:0]        SH_MAX   = (EXP_W+1)'(MAN_W + 3);
   localparam logic signed [EW-1:0]  EXP_OVF  = EW'((1 << EXP_W) - 1);
   localparam logic signed [EW-1:0]  EXP_ONE  = EW'(1);
   localparam logic signed [EW-1:0]  EXP_NIL  = EW'(0);

   state_t                 state_r, state_nxt_s;
   logic                   accept_s, busy_nxt_s, done_nxt_s;
   logic [W-1:0]           a_r, b_r;
   logic                   special_r;
   logic [W-1:0]           special_val_r;
   logic [3:0]             special_flg_r;
   logic                   sx_r, sub_r;
   logic [EXP_W-1:0]       ex_r;
   logic [MW-1:0]          mx_r, my_r;
   logic [SW-1:0]          sum_r;
   logic [MW-1:0]          nm_r;
   logic signed [EW-1:0]   ne_r;
   logic [W-1:0]           result_r;
   logic [3:0]             flags_r;
   logic                   busy_r, done_r;

   // align-stage combinational values
   logic                   sa_s, sb_s, sx_s, sy_s;
   logic [EXP_W-1:0]       ea_s, eb_s, ex_s, ey_s;
   logic [MAN_W-1:0]       fa_s, fb_s, fx_s, fy_s;
   logic                   a_nan_s, b_nan_s, a_inf_s, b_inf_s, a_ge_s;
   logic [EXP_W:0]         diff_s, sh_s;
   logic [MW-1:0]          my_pre_s, mask_s, my_al_s;
   logic                   sticky_s;
   logic                   spec_s;
   logic [W-1:0]           spec_val_s;
   logic [3:0]             spec_flg_s;
   // add / normalise / round combinational values
   logic [SW-1:0]          sum_s;
   logic [LZW-1:0]         lz_s;
   logic [MW-1:0]          nm_s;
   logic signed [EW-1:0]   ne_s;
   logic                   zero_s, uf_s;
   logic [MAN_W:0]         mant_s;
   logic [MAN_W+1:0]       mr_s;
   logic [MAN_W-1:0]       frac_s;
   logic signed [EW-1:0]   re_s;
   logic                   inc_s;
   logic [W-1:0]           round_res_s;
   logic [3:0]             round_flg_s;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_r <= S_IDLE;
      else        state_r <= state_nxt_s;
   end

   // Next-state: fixed walk through the pipeline stages, start only honoured in IDLE
   always_comb begin
      state_nxt_s = S_IDLE;
      case (state_r)
         S_IDLE:  state_nxt_s = start ? S_ALIGN : S_IDLE;
         S_ALIGN: state_nxt_s = S_ADD;
         S_ADD:   state_nxt_s = S_NORM;
         S_NORM:  state_nxt_s = S_ROUND;
         S_ROUND: state_nxt_s = S_DONE;
         S_DONE:  state_nxt_s = S_IDLE;
         default: state_nxt_s = S_IDLE;
      endcase
   end

   // Output decode: next values of the registered handshake outputs
   always_comb begin
      accept_s   = (state_r == S_IDLE) && start;
      busy_nxt_s = (state_nxt_s != S_IDLE);
      done_nxt_s = (state_nxt_s == S_DONE);
   end

   // Unpack, classify, order by magnitude and align the smaller operand
   always_comb begin
      sa_s = a_r[W-1];
      ea_s = a_r[W-2:MAN_W];
      fa_s = (ea_s != EXP_ZERO) ? a_r[MAN_W-1:0] : {MAN_W{1'b0}};
      sb_s = b_r[W-1];
      eb_s = b_r[W-2:MAN_W];
      fb_s = (eb_s != EXP_ZERO) ? b_r[MAN_W-1:0] : {MAN_W{1'b0}};
      a_nan_s = (ea_s == EXP_ONES) && (fa_s != {MAN_W{1'b0}});
      b_nan_s = (eb_s == EXP_ONES) && (fb_s != {MAN_W{1'b0}});
      a_inf_s = (ea_s == EXP_ONES) && (fa_s == {MAN_W{1'b0}});
      b_inf_s = (eb_s == EXP_ONES) && (fb_s == {MAN_W{1'b0}});
      a_ge_s  = {ea_s, fa_s} >= {eb_s, fb_s};
      if (a_ge_s) begin
         sx_s = sa_s; ex_s = ea_s; fx_s = fa_s;
         sy_s = sb_s; ey_s = eb_s; fy_s = fb_s;
      end else begin
         sx_s = sb_s; ex_s = eb_s; fx_s = fb_s;
         sy_s = sa_s; ey_s = ea_s; fy_s = fa_s;
      end
      diff_s   = {1'b0, ex_s} - {1'b0, ey_s};
      sh_s     = (diff_s > SH_MAX) ? SH_MAX : diff_s;
      my_pre_s = {(ey_s != EXP_ZERO), fy_s, 3'b000};
      mask_s   = ~({MW{1'b1}} << sh_s);
      sticky_s = |(my_pre_s & mask_s);
      my_al_s  = (my_pre_s >> sh_s) | {{(MW-1){1'b0}}, sticky_s};
      spec_flg_s = 4'b0000;
      if (a_nan_s || b_nan_s) begin
         spec_s = 1'b1; spec_val_s = QNAN;
      end else if (a_inf_s && b_inf_s && (sa_s != sb_s)) begin
         spec_s = 1'b1; spec_val_s = QNAN; spec_flg_s[FLG_NV] = 1'b1;
      end else if (a_inf_s) begin
         spec_s = 1'b1; spec_val_s = a_r;
      end else if (b_inf_s) begin
         spec_s = 1'b1; spec_val_s = b_r;
      end else begin
         spec_s = 1'b0; spec_val_s = {W{1'b0}};
      end
   end

   // Magnitude add or subtract; X >= Y so the difference never goes negative
   always_comb begin
      sum_s = sub_r ? ({1'b0, mx_r} - {1'b0, my_r}) : ({1'b0, mx_r} + {1'b0, my_r});
   end

   fp_lzc #(.WIDTH(MW)) u_lzc (
      .din   (sum_r[MW-1:0]),
      .count (lz_s)
   );

   // Normalise: absorb a carry with one right shift, else left shift by the zero count
   always_comb begin
      zero_s = (sum_r == {SW{1'b0}});
      if (sum_r[SW-1]) begin
         nm_s = {sum_r[SW-1:2], sum_r[1] | sum_r[0]};
         ne_s = $signed({2'b00, ex_r}) + EXP_ONE;
      end else begin
         nm_s = sum_r[MW-1:0] << lz_s;
         ne_s = $signed({2'b00, ex_r}) - $signed({{(EW-LZW){1'b0}}, lz_s});
      end
      uf_s = !zero_s && (ne_s <= EXP_NIL);
   end

   // Round to nearest even, then resolve overflow and previously settled specials
   always_comb begin
      mant_s = nm_r[MW-1:3];
      inc_s  = nm_r[2] & (nm_r[1] | nm_r[0] | nm_r[3]);
      mr_s   = {1'b0, mant_s} + {{(MAN_W+1){1'b0}}, inc_s};
      if (mr_s[MAN_W+1]) begin
         frac_s = mr_s[MAN_W:1];
         re_s   = ne_r + EXP_ONE;
      end else begin
         frac_s = mr_s[MAN_W-1:0];
         re_s   = ne_r;
      end
      round_flg_s = 4'b0000;
      if (special_r) begin
         round_res_s = special_val_r;
         round_flg_s = special_flg_r;
      end else if (re_s >= EXP_OVF) begin
         round_res_s = {sx_r, INF_MAG};
         round_flg_s[FLG_OF] = 1'b1;
         round_flg_s[FLG_NX] = 1'b1;
      end else begin
         round_res_s = {sx_r, re_s[EXP_W-1:0], frac_s};
         round_flg_s[FLG_NX] = nm_r[2] | nm_r[1] | nm_r[0];
      end
   end

   // Datapath registers: each stage captures its own results
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_r <= {W{1'b0}};  b_r <= {W{1'b0}};
         special_r <= 1'b0; special_val_r <= {W{1'b0}}; special_flg_r <= 4'b0000;
         sx_r <= 1'b0; sub_r <= 1'b0; ex_r <= EXP_ZERO;
         mx_r <= {MW{1'b0}}; my_r <= {MW{1'b0}};
         sum_r <= {SW{1'b0}}; nm_r <= {MW{1'b0}}; ne_r <= EXP_NIL;
      end else begin
         case (state_r)
            S_IDLE: begin
               if (start) begin
                  a_r <= a;
                  b_r <= {b[W-1] ^ op_sub, b[W-2:0]};
               end
            end
            S_ALIGN: begin
               special_r     <= spec_s;
               special_val_r <= spec_val_s;
               special_flg_r <= spec_flg_s;
               sx_r  <= sx_s;
               sub_r <= sx_s ^ sy_s;
               ex_r  <= ex_s;
               mx_r  <= {(ex_s != EXP_ZERO), fx_s, 3'b000};
               my_r  <= my_al_s;
            end
            S_ADD: sum_r <= sum_s;
            S_NORM: begin
               nm_r <= nm_s;
               ne_r <= ne_s;
               if (!special_r && zero_s) begin
                  special_r     <= 1'b1;
                  special_val_r <= {(sub_r ? 1'b0 : sx_r), {(W-1){1'b0}}};
                  special_flg_r <= 4'b0000;
               end else if (!special_r && uf_s) begin
                  special_r     <= 1'b1;
                  special_val_r <= {sx_r, {(W-1){1'b0}}};
                  special_flg_r <= 4'b0011;
               end
            end
            default: ;
         endcase
      end
   end

   // Output registers: result/flags load entering DONE, flags clear on acceptance
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result_r <= {W{1'b0}};
         flags_r  <= 4'b0000;
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
      end else begin
         busy_r <= busy_nxt_s;
         done_r <= done_nxt_s;
         if (accept_s) begin
            flags_r <= 4'b0000;
         end else if (state_r == S_ROUND) begin
            result_r <= round_res_s;
            flags_r  <= round_flg_s;
         end
      end
   end

   assign result = result_r;
   assign flags  = flags_r;
   assign busy   = busy_r;
   assign done   = done_r;

endmodule

// File: tb/tb_fp_addsub_seq.sv
// Self-checking bench for fp_addsub_seq (binary32 and binary16 instances).
// Expected results are queued when an operation is issued and compared on done.
module tb_fp_addsub_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start, op_sub;
   logic [31:0] a, b, result;
   logic [3:0]  flags;
   logic        busy, done;

   logic        start_h, op_sub_h;
   logic [15:0] a_h, b_h, result_h;
   logic [3:0]  flags_h;
   logic        busy_h, done_h;

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic [31:0] res;
      logic [3:0]  flg;
   } exp_t;

   typedef struct packed {
      logic [31:0] va;
      logic [31:0] vb;
      logic        sub;
      logic [31:0] res;
      logic [3:0]  flg;
   } vec_t;

   exp_t sb_q[$];

   vec_t vecs [18] = '{
      '{32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'h0},
      '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'h0},
      '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'h0},
      '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'h1},
      '{32'h3F800000, 32'h33800001, 1'b0, 32'h3F800001, 4'h1},
      '{32'h3FC00000, 32'h40200000, 1'b0, 32'h40800000, 4'h0},
      '{32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 4'h0},
      '{32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 4'h0},
      '{32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 4'h3},
      '{32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 4'h0},
      '{32'h3F7FFFFF, 32'h33000000, 1'b0, 32'h3F800000, 4'h1},
      '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'h5},
      '{32'hFF7FFFFF, 32'h7F7FFFFF, 1'b1, 32'hFF800000, 4'h5},
      '{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'h8},
      '{32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'h0},
      '{32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 4'h0},
      '{32'h7F800000, 32'h7F800000, 1'b0, 32'h7F800000, 4'h0},
      '{32'h3F800000, 32'hFF800001, 1'b0, 32'h7FC00000, 4'h0}
   };

   always #5 clk = ~clk;

   fp_addsub_seq dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .op_sub (op_sub),
      .a      (a),
      .b      (b),
      .result (result),
      .flags  (flags),
      .busy   (busy),
      .done   (done)
   );

   fp_addsub_seq #(.EXP_W(5), .MAN_W(10)) dut_h (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start_h),
      .op_sub (op_sub_h),
      .a      (a_h),
      .b      (b_h),
      .result (result_h),
      .flags  (flags_h),
      .busy   (busy_h),
      .done   (done_h)
   );

   // Issue one operation once the unit is idle; report edges until done (-1 on timeout)
   task automatic drive_op(input logic [31:0] ta, input logic [31:0] tb, input logic tsub,
                           output int lat, output logic busy_seen);
      @(negedge clk);
      for (int i = 0; i < 10 && busy === 1'b1; i++) @(negedge clk);
      a = ta; b = tb; op_sub = tsub; start = 1'b1;
      lat = -1;
      busy_seen = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk); #1;
         if (i == 1) begin
            start = 1'b0;
            busy_seen = busy;
         end
         if (done === 1'b1) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (result !== 32'h0) begin failures++; $display("FAIL reset_result got %h want 00000000", result); end
      checks++; if (flags !== 4'h0)   begin failures++; $display("FAIL reset_flags got %b want 0000", flags); end
      checks++; if (busy !== 1'b0)    begin failures++; $display("FAIL reset_busy got %b want 0", busy); end
      checks++; if (done !== 1'b0)    begin failures++; $display("FAIL reset_done got %b want 0", done); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_arith();
      exp_t e;
      int lat;
      logic bs;
      for (int i = 0; i < 13; i++) begin
         e.res = vecs[i].res; e.flg = vecs[i].flg;
         sb_q.push_back(e);
         drive_op(vecs[i].va, vecs[i].vb, vecs[i].sub, lat, bs);
         e = sb_q.pop_front();
         checks++; if (lat != 5)       begin failures++; $display("FAIL arith[%0d] latency got %0d want 5", i, lat); end
         checks++; if (bs !== 1'b1)    begin failures++; $display("FAIL arith[%0d] busy got %b want 1", i, bs); end
         checks++; if (result !== e.res) begin failures++; $display("FAIL arith[%0d] result got %h want %h", i, result, e.res); end
         checks++; if (flags !== e.flg)  begin failures++; $display("FAIL arith[%0d] flags got %b want %b", i, flags, e.flg); end
      end
   endtask

   task automatic test_specials();
      exp_t e;
      int lat;
      logic bs;
      for (int i = 13; i < 18; i++) begin
         e.res = vecs[i].res; e.flg = vecs[i].flg;
         sb_q.push_back(e);
         drive_op(vecs[i].va, vecs[i].vb, vecs[i].sub, lat, bs);
         e = sb_q.pop_front();
         checks++; if (lat != 5)         begin failures++; $display("FAIL special[%0d] latency got %0d want 5", i, lat); end
         checks++; if (result !== e.res) begin failures++; $display("FAIL special[%0d] result got %h want %h", i, result, e.res); end
         checks++; if (flags !== e.flg)  begin failures++; $display("FAIL special[%0d] flags got %b want %b", i, flags, e.flg); end
      end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      int lat;
      int dones;
      logic bs;
      e.res = 32'h40800000; e.flg = 4'h0;
      sb_q.push_back(e);
      drive_op(32'h3FC00000, 32'h40200000, 1'b0, lat, bs);
      e = sb_q.pop_front();
      checks++; if (result !== e.res) begin failures++; $display("FAIL b2b_first result got %h want %h", result, e.res); end
      // start raised during the DONE cycle must be dropped
      a = 32'h7F800000; b = 32'h3F800000; op_sub = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL b2b_done_pulse got %b want 0", done); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_done_start busy got %b want 0", busy); end
      dones = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (done === 1'b1) dones++;
      end
      checks++; if (dones != 0) begin failures++; $display("FAIL b2b_ignored dones got %0d want 0", dones); end
      checks++; if (result !== 32'h40800000) begin failures++; $display("FAIL b2b_hold result got %h want 40800000", result); end
      e.res = 32'h40000000; e.flg = 4'h0;
      sb_q.push_back(e);
      drive_op(32'h40400000, 32'h3F800000, 1'b1, lat, bs);
      e = sb_q.pop_front();
      checks++; if (lat != 5)         begin failures++; $display("FAIL b2b_second latency got %0d want 5", lat); end
      checks++; if (result !== e.res) begin failures++; $display("FAIL b2b_second result got %h want %h", result, e.res); end
   endtask

   task automatic test_half();
      int lat;
      int dones;
      logic [15:0] res_seen;
      logic [3:0]  flg_seen;
      exp_t e;
      e.res = 32'h00004000; e.flg = 4'h0;
      sb_q.push_back(e);
      @(negedge clk);
      a_h = 16'h3C00; b_h = 16'h3C00; op_sub_h = 1'b0; start_h = 1'b1;
      lat = -1; dones = 0; res_seen = 16'h0; flg_seen = 4'hF;
      for (int i = 1; i <= 15; i++) begin
         @(posedge clk); #1;
         if (i == 1) start_h = 1'b0;
         if (i == 2) begin start_h = 1'b1; a_h = 16'h4000; end
         if (i == 3) start_h = 1'b0;
         if (done_h === 1'b1) begin
            dones++;
            if (lat < 0) begin
               lat = i; res_seen = result_h; flg_seen = flags_h;
            end
         end
      end
      e = sb_q.pop_front();
      checks++; if (lat != 5)                begin failures++; $display("FAIL half_latency got %0d want 5", lat); end
      checks++; if (res_seen !== e.res[15:0]) begin failures++; $display("FAIL half_result got %h want %h", res_seen, e.res[15:0]); end
      checks++; if (flg_seen !== e.flg)      begin failures++; $display("FAIL half_flags got %b want %b", flg_seen, e.flg); end
      checks++; if (dones != 1)              begin failures++; $display("FAIL half_busy_start dones got %0d want 1", dones); end
   endtask

   task automatic test_reset_midop();
      exp_t e;
      int lat;
      int dones;
      logic bs;
      @(negedge clk);
      for (int i = 0; i < 10 && busy === 1'b1; i++) @(negedge clk);
      a = 32'h3F800000; b = 32'h3F800000; op_sub = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      checks++; if (result !== 32'h0) begin failures++; $display("FAIL midrst_result got %h want 00000000", result); end
      checks++; if (flags !== 4'h0)   begin failures++; $display("FAIL midrst_flags got %b want 0000", flags); end
      checks++; if (busy !== 1'b0)    begin failures++; $display("FAIL midrst_busy got %b want 0", busy); end
      checks++; if (done !== 1'b0)    begin failures++; $display("FAIL midrst_done got %b want 0", done); end
      dones = 0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (done === 1'b1) dones++;
      end
      checks++; if (dones != 0) begin failures++; $display("FAIL midrst_no_done got %0d want 0", dones); end
      e.res = 32'h3F800001; e.flg = 4'h1;
      sb_q.push_back(e);
      drive_op(32'h3F800000, 32'h33800001, 1'b0, lat, bs);
      e = sb_q.pop_front();
      checks++; if (lat != 5)         begin failures++; $display("FAIL midrst_next latency got %0d want 5", lat); end
      checks++; if (result !== e.res) begin failures++; $display("FAIL midrst_next result got %h want %h", result, e.res); end
      checks++; if (flags !== e.flg)  begin failures++; $display("FAIL midrst_next flags got %b want %b", flags, e.flg); end
   endtask

   initial begin
      start = 1'b0; op_sub = 1'b0; a = 32'h0; b = 32'h0;
      start_h = 1'b0; op_sub_h = 1'b0; a_h = 16'h0; b_h = 16'h0;
      test_reset();
      test_arith();
      test_specials();
      test_back_to_back();
      test_half();
      test_reset_midop();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1);
   end

endmodule
